// File: rtl/reg32_arb_pkg.sv
// Shared types, constants and small decode helpers for the three-writer
// configuration-register arbiter.
package reg32_arb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned GNT_W   = 2;
    localparam logic [GNT_W-1:0] GNT_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    // Request bit of requester idx; an out-of-range index reads as no request.
    function automatic logic req_bit(input logic [NUM_REQ-1:0] req_vec,
                                     input logic [GNT_W-1:0]   idx);
        logic bit_v;
        case (idx)
            2'd0:    bit_v = req_vec[0];
            2'd1:    bit_v = req_vec[1];
            2'd2:    bit_v = req_vec[2];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [GNT_W-1:0] idx);
        logic [NUM_REQ-1:0] oh_v;
        case (idx)
            2'd0:    oh_v = 3'b001;
            2'd1:    oh_v = 3'b010;
            2'd2:    oh_v = 3'b100;
            default: oh_v = 3'b000;
        endcase
        return oh_v;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational round-robin picker for three requesters; search starts at the
// requester following the last winner.
module rr_arb3
    import reg32_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GNT_W-1:0]   rr_last_i,
    output logic               gnt_valid_o,
    output logic [GNT_W-1:0]   gnt_idx_o
);

    logic [GNT_W-1:0] ord0_s;
    logic [GNT_W-1:0] ord1_s;
    logic [GNT_W-1:0] ord2_s;

    // Priority order derived from the last winner.
    always_comb begin
        case (rr_last_i)
            2'd0: begin
                ord0_s = 2'd1;
                ord1_s = 2'd2;
                ord2_s = 2'd0;
            end
            2'd1: begin
                ord0_s = 2'd2;
                ord1_s = 2'd0;
                ord2_s = 2'd1;
            end
            default: begin
                ord0_s = 2'd0;
                ord1_s = 2'd1;
                ord2_s = 2'd2;
            end
        endcase
    end

    // First requesting index in priority order wins.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = GNT_NONE;
        if (req_bit(req_i, ord0_s)) begin
            gnt_idx_o = ord0_s;
        end else if (req_bit(req_i, ord1_s)) begin
            gnt_idx_o = ord1_s;
        end else if (req_bit(req_i, ord2_s)) begin
            gnt_idx_o = ord2_s;
        end else begin
            gnt_idx_o = GNT_NONE;
        end
    end

endmodule

// File: rtl/reg32_write_arbiter.sv
// Round-robin arbitrated write port for one shared configuration register:
// grant, commit and a one-cycle ack per transaction, with an external lockout.
module reg32_write_arbiter
    import reg32_arb_pkg::*;
#(
    parameter int unsigned          WIDTH   = 32,
    parameter logic [WIDTH-1:0]     RST_VAL = '0,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             req2,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             busy_in,
    output logic             ack0,
    output logic             ack1,
    output logic             ack2,
    output logic [WIDTH-1:0] reg_out,
    output logic             busy_out,
    output logic [GNT_W-1:0] grant_id,
    output logic [CNT_W-1:0] wr_count
);

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   reg_q,     reg_d;
    logic [NUM_REQ-1:0] ack_q,     ack_d;
    logic               busy_q,    busy_d;
    logic [GNT_W-1:0]   gnt_q,     gnt_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [GNT_W-1:0]   rr_last_q, rr_last_d;

    logic [NUM_REQ-1:0] req_vec_s;
    logic               arb_valid_s;
    logic [GNT_W-1:0]   arb_idx_s;
    logic [WIDTH-1:0]   data_sel_s;

    assign req_vec_s = {req2, req1, req0};

    rr_arb3 u_rr_arb3 (
        .req_i       (req_vec_s),
        .rr_last_i   (rr_last_q),
        .gnt_valid_o (arb_valid_s),
        .gnt_idx_o   (arb_idx_s)
    );

    // Write data of the currently granted requester.
    always_comb begin
        case (gnt_q)
            2'd0:    data_sel_s = data0;
            2'd1:    data_sel_s = data1;
            2'd2:    data_sel_s = data2;
            default: data_sel_s = '0;
        endcase
    end

    // Next-state and registered-output logic; ack defaults low so it pulses.
    always_comb begin
        state_d   = state_q;
        reg_d     = reg_q;
        ack_d     = 3'b000;
        busy_d    = busy_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (!busy_in && arb_valid_s) begin
                    state_d   = WRITE;
                    gnt_d     = arb_idx_s;
                    busy_d    = 1'b1;
                    rr_last_d = arb_idx_s;
                end else begin
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                // busy_in is deliberately not consulted: a grant always finishes.
                if (req_bit(req_vec_s, gnt_q)) begin
                    state_d = ACK;
                    reg_d   = data_sel_s;
                    ack_d   = idx_onehot(gnt_q);
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    gnt_d   = GNT_NONE;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                gnt_d   = GNT_NONE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            reg_q     <= RST_VAL;
            ack_q     <= 3'b000;
            busy_q    <= 1'b0;
            gnt_q     <= GNT_NONE;
            cnt_q     <= '0;
            rr_last_q <= 2'd2;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign ack2     = ack_q[2];
    assign reg_out  = reg_q;
    assign busy_out = busy_q;
    assign grant_id = gnt_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg32_write_arbiter.sv
// Directed bench for reg32_write_arbiter: a scoreboard queue holds the expected
// committed writes, popped and compared whenever an ack appears.
module tb_reg32_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, req2;
    logic [31:0] data0, data1, data2;
    logic        busy_in;
    logic        ack0, ack1, ack2;
    logic [31:0] reg_out;
    logic        busy_out;
    logic [1:0]  grant_id;
    logic [7:0]  wr_count;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [2:0]  mon_oh;
    logic [7:0]  exp_cnt = 8'd0;
    int          passed  = 0;
    int          total   = 0;

    reg32_write_arbiter #(.WIDTH(32), .RST_VAL(32'h0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .req2(req2),
        .data0(data0), .data1(data1), .data2(data2),
        .busy_in(busy_in),
        .ack0(ack0), .ack1(ack1), .ack2(ack2),
        .reg_out(reg_out), .busy_out(busy_out),
        .grant_id(grant_id), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] d);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{id: id, data: d, cnt: exp_cnt});
    endtask

    // Scoreboard side: every ack must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && (ack0 || ack1 || ack2)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {29'd0, ack2, ack1, ack0}, 32'd0);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 3'b001 << mon_e.id;
                chk("ack_vec", {29'd0, ack2, ack1, ack0}, {29'd0, mon_oh});
                chk("ack_reg", reg_out, mon_e.data);
                chk("ack_cnt", {24'd0, wr_count}, {24'd0, mon_e.cnt});
            end
        end
    end

    initial begin
        rst = 1'b1; busy_in = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        data0 = 32'd0; data1 = 32'd0; data2 = 32'd0;
        cyc(); cyc();
        chk("rst_reg", reg_out, 32'd0);
        chk("rst_ack", {29'd0, ack2, ack1, ack0}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_gnt", {30'd0, grant_id}, 32'd3);
        chk("rst_cnt", {24'd0, wr_count}, 32'd0);
        rst = 1'b0;
        cyc();

        // Three-way contention, fresh priority: order 0,1,2
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        data0 = 32'h11; data1 = 32'h22; data2 = 32'h33;
        push(2'd0, 32'h11); push(2'd1, 32'h22); push(2'd2, 32'h33);
        cyc();
        chk("c_gnt0", {30'd0, grant_id}, 32'd0);
        chk("c_busy", {31'd0, busy_out}, 32'd1);
        cyc();
        chk("c_ack0", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        cyc();
        chk("c_idle", {30'd0, grant_id}, 32'd3);
        cyc();
        chk("c_gnt1", {30'd0, grant_id}, 32'd1);
        cyc();
        chk("c_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0;
        cyc(); cyc();
        chk("c_gnt2", {30'd0, grant_id}, 32'd2);
        cyc();
        chk("c_ack2", {31'd0, ack2}, 32'd1);
        req2 = 1'b0;
        cyc();
        chk("c_reg", reg_out, 32'h33);
        chk("c_cnt", {24'd0, wr_count}, 32'd3);

        // Single write from requester 1
        req1 = 1'b1; data1 = 32'hDEADBEEF;
        push(2'd1, 32'hDEADBEEF);
        cyc();
        chk("s_gnt", {30'd0, grant_id}, 32'd1);
        cyc();
        chk("s_ack1", {31'd0, ack1}, 32'd1);
        chk("s_reg", reg_out, 32'hDEADBEEF);
        req1 = 1'b0;
        cyc();
        chk("s_busy", {31'd0, busy_out}, 32'd0);
        chk("s_gnt_idle", {30'd0, grant_id}, 32'd3);
        chk("s_cnt", {24'd0, wr_count}, 32'd4);

        // Lockout: busy_in holds off requester 2
        busy_in = 1'b1; req2 = 1'b1; data2 = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("l_nogrant", {29'd0, busy_out, grant_id}, {29'd0, 1'b0, 2'd3});
        end
        chk("l_reg", reg_out, 32'hDEADBEEF);
        busy_in = 1'b0;
        push(2'd2, 32'h12345678);
        cyc();
        chk("l_gnt", {30'd0, grant_id}, 32'd2);
        cyc();
        chk("l_ack2", {31'd0, ack2}, 32'd1);
        req2 = 1'b0;
        cyc();

        // Abort: requester 0 drops during WRITE
        req0 = 1'b1; data0 = 32'hCAFE0000;
        cyc();
        chk("a_gnt", {30'd0, grant_id}, 32'd0);
        req0 = 1'b0;
        cyc();
        chk("a_idle", {29'd0, busy_out, grant_id}, {29'd0, 1'b0, 2'd3});
        chk("a_ack", {29'd0, ack2, ack1, ack0}, 32'd0);
        chk("a_reg", reg_out, 32'h12345678);
        chk("a_cnt", {24'd0, wr_count}, 32'd5);

        // Reset during WRITE loses the write
        req1 = 1'b1; data1 = 32'hA5A5A5A5;
        cyc();
        chk("r_gnt", {30'd0, grant_id}, 32'd1);
        rst = 1'b1;
        #1;
        chk("r_reg", reg_out, 32'd0);
        chk("r_idle", {29'd0, busy_out, grant_id}, {29'd0, 1'b0, 2'd3});
        chk("r_cnt", {24'd0, wr_count}, 32'd0);
        req1 = 1'b0;
        exp_cnt = 8'd0;
        cyc();
        chk("r_ack", {29'd0, ack2, ack1, ack0}, 32'd0);
        rst = 1'b0;
        cyc();
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        cyc();
        chk("r_first", {30'd0, grant_id}, 32'd0);
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        cyc();
        chk("r_abort_idle", {30'd0, grant_id}, 32'd3);

        // Counter wrap: 257 writes leave wr_count at 1
        for (int i = 0; i < 257; i++) begin
            req0 = 1'b1; data0 = 32'h1000 + 32'(i);
            push(2'd0, 32'h1000 + 32'(i));
            cyc(); cyc();
            req0 = 1'b0;
            cyc();
        end
        chk("w_cnt", {24'd0, wr_count}, 32'd1);
        chk("w_reg", reg_out, 32'h1100);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
